// File: rtl/image_scan_controller_if.sv
// Scan-controller handshake bundle: frame request/stall in, pixel coordinate
// stream and frame status out.
interface image_scan_controller_if #(
    parameter int COL_BITS  = 10,
    parameter int ROW_BITS  = 9,
    parameter int ADDR_BITS = 19
);
    logic                 start;
    logic                 stall;
    logic                 busy;
    logic                 pixel_valid;
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic [ADDR_BITS-1:0] addr;
    logic                 line_end;
    logic                 frame_end;
    logic                 done;

    modport master (
        output start, stall,
        input  busy, pixel_valid, col, row, addr, line_end, frame_end, done
    );

    modport slave (
        input  start, stall,
        output busy, pixel_valid, col, row, addr, line_end, frame_end, done
    );
endinterface

// File: rtl/image_scan_controller.sv
// Raster scan address generator: walks every pixel of an IMG_WIDTH x IMG_HEIGHT
// frame in row-major order, holding position while downstream stalls.
module image_scan_controller #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 9,
    parameter int ADDR_BITS  = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    image_scan_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scanState_t;

    localparam logic [COL_BITS-1:0]  LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [COL_BITS-1:0]  COL_ONE  = COL_BITS'(1'b1);
    localparam logic [ROW_BITS-1:0]  ROW_ONE  = ROW_BITS'(1'b1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1'b1);

    scanState_t           state;
    logic [COL_BITS-1:0]  colCnt;
    logic [ROW_BITS-1:0]  rowCnt;
    logic [ADDR_BITS-1:0] addrCnt;
    logic                 atLastCol;
    logic                 atLastRow;

    assign atLastCol = (colCnt == LAST_COL);
    assign atLastRow = (rowCnt == LAST_ROW);

    // Scan state and position counters; addr advances alongside col so it
    // always equals row*IMG_WIDTH + col without a multiplier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            colCnt  <= '0;
            rowCnt  <= '0;
            addrCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SCAN;
                        colCnt  <= '0;
                        rowCnt  <= '0;
                        addrCnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (!bus.stall) begin
                        if (!atLastCol) begin
                            colCnt  <= colCnt + COL_ONE;
                            addrCnt <= addrCnt + ADDR_ONE;
                        end else if (!atLastRow) begin
                            colCnt  <= '0;
                            rowCnt  <= rowCnt + ROW_ONE;
                            addrCnt <= addrCnt + ADDR_ONE;
                        end else begin
                            state   <= DONE;
                            colCnt  <= '0;
                            rowCnt  <= '0;
                            addrCnt <= '0;
                        end
                    end else begin
                        state <= SCAN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    colCnt  <= '0;
                    rowCnt  <= '0;
                    addrCnt <= '0;
                end
            endcase
        end
    end

    // Status decodes are zero-latency views of the state and counters.
    assign bus.pixel_valid = (state == SCAN);
    assign bus.busy        = (state == SCAN) || (state == DONE);
    assign bus.done        = (state == DONE);
    assign bus.line_end    = (state == SCAN) && atLastCol;
    assign bus.frame_end   = (state == SCAN) && atLastCol && atLastRow;
    assign bus.col         = colCnt;
    assign bus.row         = rowCnt;
    assign bus.addr        = addrCnt;
endmodule

// File: tb/tb_image_scan_controller.sv
// Directed + randomized bench for image_scan_controller on a 4x3 frame, checked
// against a pixel-index reference model.
module tb_image_scan_controller;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: scanning flag, one-cycle done flag, count of accepted pixels.
    bit mScan;
    bit mDone;
    int mK;

    image_scan_controller_if #(.COL_BITS(2), .ROW_BITS(2), .ADDR_BITS(4)) bus ();

    image_scan_controller #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_BITS  (2),
        .ROW_BITS  (2),
        .ADDR_BITS (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("pixel_valid", 32'(bus.pixel_valid), 32'(mScan));
        check("busy",        32'(bus.busy),        32'(mScan | mDone));
        check("done",        32'(bus.done),        32'(mDone));
        check("col",         32'(bus.col),         32'(mK % W));
        check("row",         32'(bus.row),         32'(mK / W));
        check("addr",        32'(bus.addr),        32'(mK));
        check("line_end",    32'(bus.line_end),    32'(mScan && (mK % W) == W - 1));
        check("frame_end",   32'(bus.frame_end),   32'(mScan && mK == N - 1));
    endtask

    task automatic modelReset();
        mScan = 1'b0;
        mDone = 1'b0;
        mK    = 0;
    endtask

    task automatic modelStep(input bit st, input bit sl);
        if (reset) begin
            modelReset();
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mScan) begin
            if (!sl) begin
                mK = mK + 1;
                if (mK == N) begin
                    mK    = 0;
                    mScan = 1'b0;
                    mDone = 1'b1;
                end
            end
        end else if (st) begin
            mScan = 1'b1;
            mK    = 0;
        end
    endtask

    // One clock with the given inputs; outputs sampled on the falling edge.
    task automatic cycle(input bit st, input bit sl);
        bus.start = st;
        bus.stall = sl;
        @(posedge clock);
        modelStep(st, sl);
        @(negedge clock);
        checkAll();
    endtask

    task automatic runTo(input int target);
        for (int i = 0; i < 40 && !(mScan && mK == target); i++) cycle(1'b0, 1'b0);
        check("runTo_addr", 32'(bus.addr), 32'(target));
    endtask

    initial begin
        int doneCount;
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        reset = 1'b0;
        modelReset();

        // Reset pulse; start is ignored while reset is held.
        #2 reset = 1'b1;
        #1 checkAll();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        reset = 1'b0;

        // Start on the first edge after release, then an unstalled frame.
        cycle(1'b1, 1'b0);
        check("first_pixel_valid", 32'(bus.pixel_valid), 32'd1);
        doneCount = 0;
        for (int i = 0; i < N + 2; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.done) doneCount++;
        end
        check("done_count_plain", 32'(doneCount), 32'd1);
        check("idle_after_frame", 32'(bus.busy), 32'd0);

        // Stall three cycles at (1,1), then row/col wrap through the rest.
        cycle(1'b1, 1'b0);
        runTo(3);
        cycle(1'b0, 1'b0);
        check("wrap_col", 32'(bus.col), 32'd0);
        check("wrap_row", 32'(bus.row), 32'd1);
        runTo(5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("stall_hold_addr", 32'(bus.addr), 32'd5);
        cycle(1'b0, 1'b0);
        check("after_stall_addr", 32'(bus.addr), 32'd6);
        runTo(N - 1);

        // Stall on frame_end: stays on last pixel, no DONE until released.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
        check("frame_end_held", 32'(bus.frame_end), 32'd1);
        cycle(1'b1, 1'b0);
        check("done_after_release", 32'(bus.done), 32'd1);
        cycle(1'b1, 1'b0);

        // Start held high: back-to-back frames with start ignored during SCAN.
        doneCount = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            cycle(1'b1, 1'b0);
            if (bus.done) doneCount++;
        end
        check("done_count_b2b", 32'(doneCount), 32'd3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Asynchronous reset at addr 7 aborts the frame.
        cycle(1'b1, 1'b0);
        runTo(7);
        #2 reset = 1'b1;
        #1 modelReset();
        checkAll();
        @(negedge clock);
        cycle(1'b0, 1'b0);
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.done) doneCount++;
        end
        check("no_done_after_abort", 32'(doneCount), 32'd0);

        // Randomized start/stall traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
